fetch_decode: RTL and testbench

//  Front-end of the picoMIPS core: owns the program counter and drives the program ROM address.

---
 rtl/cpuConfig.sv | 29 ++
 rtl/fetch_decode.sv | 81 ++++++++
 tb/tb_fetch_decode.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/cpuConfig.sv
// Shared picoMIPS sizes, opcode and ALU function encodings.
package cpuConfig;

  localparam int unsigned N      = 8;
  localparam int unsigned O_SIZE = 4;
  localparam int unsigned P_SIZE = 5;
  localparam int unsigned R_SIZE = 4;
  localparam int unsigned I_SIZE = O_SIZE + 2 * R_SIZE + N;

  typedef enum logic [O_SIZE-1:0] {
    NOP   = 4'd0,
    LDI   = 4'd1,
    LDS   = 4'd2,
    ADD   = 4'd3,
    ADDI  = 4'd4,
    MUL   = 4'd5,
    MULI  = 4'd6,
    WAIT0 = 4'd7,
    WAIT1 = 4'd8
  } opCode_t;

  typedef enum logic [1:0] {
    ALU_A   = 2'd0,
    ALU_B   = 2'd1,
    ALU_ADD = 2'd2,
    ALU_MUL = 2'd3
  } aluFunc_t;

endpackage

// File: rtl/fetch_decode.sv
// picoMIPS front-end: PC, instruction register, SW8 synchroniser and decode.
module fetch_decode
  import cpuConfig::*;
(
  input  logic              clk,
  input  logic              nReset,
  output logic [P_SIZE-1:0] pcAddr,
  input  logic [I_SIZE-1:0] instr,
  input  logic              sw8,
  output logic              regWe,
  output logic [1:0]        aluFunc,
  output logic [1:0]        bSel,
  output logic [R_SIZE-1:0] rdAddr,
  output logic [R_SIZE-1:0] rsAddr,
  output logic [N-1:0]      imm,
  output logic              waiting,
  output logic              illegalOp
);

  localparam int unsigned OP_LSB = 2 * R_SIZE + N;
  localparam int unsigned RD_LSB = R_SIZE + N;
  localparam int unsigned RS_LSB = N;

  logic [P_SIZE-1:0] pc;
  logic [I_SIZE-1:0] ir;
  logic              sw8_meta;
  logic              sw8s;
  logic              adv;
  opCode_t           op;
  aluFunc_t          alu_func;

  assign op = opCode_t'(ir[I_SIZE-1:OP_LSB]);

  // Stall while a WAIT in IR has not yet seen its awaited synchronised switch level.
  assign adv = !((op == WAIT0) && sw8s) && !((op == WAIT1) && !sw8s);

  // PC, IR and SW8 synchroniser; fetch advances only when not stalled.
  always_ff @(posedge clk) begin
    if (!nReset) begin
      pc       <= '0;
      ir       <= '0;
      sw8_meta <= 1'b0;
      sw8s     <= 1'b0;
    end else begin
      sw8_meta <= sw8;
      sw8s     <= sw8_meta;
      if (adv) begin
        ir <= instr;
        pc <= pc + P_SIZE'(1);
      end
    end
  end

  // Decode the IR opcode into register-file and ALU controls.
  always_comb begin
    regWe     = 1'b0;
    alu_func  = ALU_A;
    bSel      = 2'd0;
    illegalOp = 1'b0;
    case (op)
      NOP:   ;
      LDI:   begin regWe = 1'b1; alu_func = ALU_B;   bSel = 2'd1; end
      LDS:   begin regWe = 1'b1; alu_func = ALU_B;   bSel = 2'd2; end
      ADD:   begin regWe = 1'b1; alu_func = ALU_ADD; bSel = 2'd0; end
      ADDI:  begin regWe = 1'b1; alu_func = ALU_ADD; bSel = 2'd1; end
      MUL:   begin regWe = 1'b1; alu_func = ALU_MUL; bSel = 2'd0; end
      MULI:  begin regWe = 1'b1; alu_func = ALU_MUL; bSel = 2'd1; end
      WAIT0: ;
      WAIT1: ;
      default: illegalOp = 1'b1;
    endcase
  end

  assign aluFunc = alu_func;
  assign pcAddr  = pc;
  assign rdAddr  = ir[RD_LSB +: R_SIZE];
  assign rsAddr  = ir[RS_LSB +: R_SIZE];
  assign imm     = ir[N-1:0];
  assign waiting = !adv;

endmodule

// File: tb/tb_fetch_decode.sv
// Directed self-checking bench for fetch_decode.
module tb_fetch_decode;

  localparam logic [1:0] A_A   = 2'd0;
  localparam logic [1:0] A_B   = 2'd1;
  localparam logic [1:0] A_ADD = 2'd2;
  localparam logic [1:0] A_MUL = 2'd3;

  logic        clk;
  logic        nReset;
  logic [4:0]  pcAddr;
  logic [19:0] instr;
  logic        sw8;
  logic        regWe;
  logic [1:0]  aluFunc;
  logic [1:0]  bSel;
  logic [3:0]  rdAddr;
  logic [3:0]  rsAddr;
  logic [7:0]  imm;
  logic        waiting;
  logic        illegalOp;

  logic [19:0] rom [32];
  int          errors;
  int          checks;

  assign instr = rom[pcAddr];

  fetch_decode dut (
    .clk       (clk),
    .nReset    (nReset),
    .pcAddr    (pcAddr),
    .instr     (instr),
    .sw8       (sw8),
    .regWe     (regWe),
    .aluFunc   (aluFunc),
    .bSel      (bSel),
    .rdAddr    (rdAddr),
    .rsAddr    (rsAddr),
    .imm       (imm),
    .waiting   (waiting),
    .illegalOp (illegalOp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] ins(input logic [3:0] op, input logic [3:0] rd,
                                      input logic [3:0] rs, input logic [7:0] im);
    return {op, rd, rs, im};
  endfunction

  initial begin
    errors = 0;
    checks = 0;
    nReset = 1'b0;
    sw8    = 1'b0;
    for (int i = 0; i < 32; i++) rom[i] = '0;

    // Reset held for three edges
    repeat (3) @(negedge clk);
    chk("rst_pc",      32'(pcAddr),    32'd0);
    chk("rst_regwe",   32'(regWe),     32'd0);
    chk("rst_alu",     32'(aluFunc),   32'(A_A));
    chk("rst_bsel",    32'(bSel),      32'd0);
    chk("rst_wait",    32'(waiting),   32'd0);
    chk("rst_illegal", 32'(illegalOp), 32'd0);
    chk("rst_imm",     32'(imm),       32'd0);

    // Program for straight line, WAIT1 stall and WAIT0 pass-through
    rom[0] = ins(4'd1, 4'd1, 4'd0, 8'd5);   // LDI r1,#5
    rom[1] = ins(4'd4, 4'd1, 4'd0, 8'd3);   // ADDI r1,#3
    rom[2] = ins(4'd5, 4'd1, 4'd2, 8'd0);   // MUL r1,r2
    rom[4] = ins(4'd8, 4'd0, 4'd0, 8'd0);   // WAIT1
    rom[5] = ins(4'd2, 4'd3, 4'd0, 8'd0);   // LDS r3
    rom[6] = ins(4'd7, 4'd0, 4'd0, 8'd0);   // WAIT0
    rom[7] = ins(4'd3, 4'd4, 4'd5, 8'd0);   // ADD r4,r5
    rom[8] = ins(4'd8, 4'd0, 4'd0, 8'd0);   // WAIT1
    nReset = 1'b1;

    @(negedge clk);                         // IR = LDI
    chk("ldi_pc",    32'(pcAddr),  32'd1);
    chk("ldi_regwe", 32'(regWe),   32'd1);
    chk("ldi_alu",   32'(aluFunc), 32'(A_B));
    chk("ldi_bsel",  32'(bSel),    32'd1);
    chk("ldi_imm",   32'(imm),     32'd5);
    chk("ldi_rd",    32'(rdAddr),  32'd1);
    @(negedge clk);                         // IR = ADDI
    chk("addi_regwe", 32'(regWe),   32'd1);
    chk("addi_alu",   32'(aluFunc), 32'(A_ADD));
    chk("addi_bsel",  32'(bSel),    32'd1);
    chk("addi_imm",   32'(imm),     32'd3);
    @(negedge clk);                         // IR = MUL
    chk("mul_alu",  32'(aluFunc), 32'(A_MUL));
    chk("mul_bsel", 32'(bSel),    32'd0);
    chk("mul_rs",   32'(rsAddr),  32'd2);
    chk("mul_pc",   32'(pcAddr),  32'd3);

    @(negedge clk);                         // IR = NOP (rom[3])
    @(negedge clk);                         // IR = WAIT1, sw8s = 0
    chk("w1_wait",  32'(waiting), 32'd1);
    chk("w1_pc",    32'(pcAddr),  32'd5);
    chk("w1_regwe", 32'(regWe),   32'd0);
    @(negedge clk);
    chk("w1_hold_wait", 32'(waiting), 32'd1);
    chk("w1_hold_pc",   32'(pcAddr),  32'd5);
    sw8 = 1'b1;
    @(negedge clk);                         // first synchroniser stage only
    chk("w1_edge1_wait", 32'(waiting), 32'd1);
    chk("w1_edge1_pc",   32'(pcAddr),  32'd5);
    @(negedge clk);                         // sw8s = 1
    chk("w1_edge2_wait", 32'(waiting), 32'd0);
    chk("w1_edge2_pc",   32'(pcAddr),  32'd5);
    sw8 = 1'b0;
    @(negedge clk);                         // IR = LDS
    chk("lds_pc",    32'(pcAddr),  32'd6);
    chk("lds_bsel",  32'(bSel),    32'd2);
    chk("lds_alu",   32'(aluFunc), 32'(A_B));
    chk("lds_regwe", 32'(regWe),   32'd1);
    chk("lds_rd",    32'(rdAddr),  32'd3);

    @(negedge clk);                         // IR = WAIT0, sw8s = 0
    chk("w0_wait",  32'(waiting), 32'd0);
    chk("w0_pc",    32'(pcAddr),  32'd7);
    chk("w0_regwe", 32'(regWe),   32'd0);
    @(negedge clk);                         // IR = ADD
    chk("add_pc",   32'(pcAddr),  32'd8);
    chk("add_wait", 32'(waiting), 32'd0);
    chk("add_alu",  32'(aluFunc), 32'(A_ADD));
    chk("add_bsel", 32'(bSel),    32'd0);
    chk("add_rs",   32'(rsAddr),  32'd5);

    @(negedge clk);                         // IR = WAIT1, stalled
    chk("w1b_wait", 32'(waiting), 32'd1);
    chk("w1b_pc",   32'(pcAddr),  32'd9);
    rom[0] = ins(4'hF, 4'd0, 4'd0, 8'hA5);
    nReset = 1'b0;
    @(negedge clk);                         // reset mid-stall
    chk("rst2_pc",   32'(pcAddr),  32'd0);
    chk("rst2_wait", 32'(waiting), 32'd0);
    chk("rst2_alu",  32'(aluFunc), 32'(A_A));
    nReset = 1'b1;
    @(negedge clk);                         // IR = illegal op
    chk("ill_flag",  32'(illegalOp), 32'd1);
    chk("ill_regwe", 32'(regWe),     32'd0);
    chk("ill_pc",    32'(pcAddr),    32'd1);
    chk("ill_imm",   32'(imm),       32'hA5);
    @(negedge clk);                         // IR = ADDI
    chk("ill_clear", 32'(illegalOp), 32'd0);
    chk("ill_pc2",   32'(pcAddr),    32'd2);

    // PC wrap with an all-NOP program
    for (int i = 0; i < 32; i++) rom[i] = '0;
    nReset = 1'b0;
    @(negedge clk);
    nReset = 1'b1;
    chk("wrap_start", 32'(pcAddr), 32'd0);
    for (int i = 1; i <= 33; i++) begin
      @(negedge clk);
      chk($sformatf("wrap_pc%0d", i), 32'(pcAddr), 32'(i % 32));
    end
    chk("wrap_wait", 32'(waiting), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time bound so the bench always terminates
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
